// File: rtl/pcpi_fpsq_pkg.sv
// rtl/pcpi_fpsq_pkg.sv - shared types, widths and constants for the PCPI FP sum/difference-of-squares unit
// Purpose: FSM state encoding, IEEE-754 single field widths, special result
//          encodings, the R-type opcode and a 48-bit leading-zero counter.
// Ports:   none (package).
package pcpi_fpsq_pkg;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    // Wide enough for 2e-127+1 (max 382), the NORM increment and the
    // difference-path leading-zero decrement (min about -172).
    localparam int EXPX_W = 11;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP_PINF = 32'h7F80_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    localparam logic [6:0] OPCODE_OP = 7'b0110011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQ_A,
        S_SQ_B,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_RESP,
        S_COOL
    } state_t;

    // Leading-zero count of a 48-bit vector; ascending scan lets the
    // highest set bit win. An all-zero input returns 0.
    function automatic logic [5:0] lzc48(input logic [PROD_W-1:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < PROD_W; i++) begin
            if (v[i]) n = 6'(47 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/pcpi_fp_sumsq_if.sv
// rtl/pcpi_fp_sumsq_if.sv - PCPI co-processor bus bundle
// Purpose: groups the PCPI request/response signals.
// Modports: master = core side (drives valid/insn/rs1/rs2),
//           slave  = co-processor side (drives wr/rd/wait/ready).
interface pcpi_fp_sumsq_if;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    modport master (
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );

    modport slave (
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );
endinterface

// File: rtl/fp_square.sv
// rtl/fp_square.sv - combinational IEEE-754 single significand squarer
// Purpose: squares the 24-bit significand (hidden 1) into a 48-bit product
//          normalised so bit 47 is the leading one, with biased exponent.
// Ports:   i_exp  - biased exponent of the operand
//          i_man  - stored mantissa of the operand
//          o_sig  - normalised 48-bit squared significand (0 when o_zero)
//          o_exp  - signed biased exponent of the square
//          o_zero - operand is zero or denormal (flushed)
module fp_square
    import pcpi_fpsq_pkg::*;
(
    input  logic        [EXP_W-1:0]  i_exp,
    input  logic        [MAN_W-1:0]  i_man,
    output logic        [PROD_W-1:0] o_sig,
    output logic signed [EXPX_W-1:0] o_exp,
    output logic                     o_zero
);

    logic [PROD_W-1:0] w_sig_in;
    logic [PROD_W-1:0] w_prod;

    assign o_zero   = (i_exp == '0);
    assign w_sig_in = {24'd0, 1'b1, i_man};
    assign w_prod   = w_sig_in * w_sig_in;

    // Product of two [1,2) values lies in [1,4): either bit 47 or bit 46 leads.
    assign o_sig = o_zero ? '0 : (w_prod[47] ? w_prod : {w_prod[46:0], 1'b0});
    assign o_exp = $signed({2'b00, i_exp, 1'b0}) - 11'sd127
                 + $signed({10'd0, w_prod[47]});

endmodule

// File: rtl/pcpi_fp_sumsq.sv
// rtl/pcpi_fp_sumsq.sv - PCPI co-processor computing rd = rs1^2 + rs2^2 in IEEE-754 single
// Purpose: decodes the SUMSQ R-type instruction, runs a fixed 8-state
//          sequence (square a, square b, align, add, normalise, respond,
//          cool-down) and returns a truncated single-precision result.
// Ports:   clk   - rising-edge clock
//          reset - synchronous active-high reset
//          bus   - pcpi_fp_sumsq_if.slave (valid/insn/rs1/rs2 in,
//                  wr/rd/wait/ready out)
// Macro:   PCPI_FPSQ_DIFF_EN - adds DIFFSQ (funct3=001, rd = rs1^2 - rs2^2).
module pcpi_fp_sumsq
    import pcpi_fpsq_pkg::*;
#(
    parameter logic [6:0] FUNCT7 = 7'b0000001
)(
    input  logic                  clk,
    input  logic                  reset,
    pcpi_fp_sumsq_if.slave        bus
);

    state_t r_state, w_next_state;

    logic [31:0]              r_rs1, r_rs2;
    logic [PROD_W-1:0]        r_sig_a, r_sig_b;
    logic signed [EXPX_W-1:0] r_exp_a, r_exp_b;
    logic                     r_zero_a, r_zero_b;
    logic [PROD_W-1:0]        r_sig_big, r_sig_small;
    logic signed [EXPX_W-1:0] r_exp_big;
    logic                     r_b_bigger;
    logic [PROD_W:0]          r_sum;
    logic signed [EXPX_W-1:0] r_exp_sum;
    logic [31:0]              r_result;

    // ---------------- decode ----------------
    logic w_match_sum, w_match, w_accept;
    assign w_match_sum = (bus.pcpi_insn[6:0] == OPCODE_OP) &&
                         (bus.pcpi_insn[31:25] == FUNCT7) &&
                         (bus.pcpi_insn[14:12] == 3'b000);
`ifdef PCPI_FPSQ_DIFF_EN
    logic w_match_diff;
    logic r_op_diff;
    assign w_match_diff = (bus.pcpi_insn[6:0] == OPCODE_OP) &&
                          (bus.pcpi_insn[31:25] == FUNCT7) &&
                          (bus.pcpi_insn[14:12] == 3'b001);
    assign w_match = w_match_sum | w_match_diff;
`else
    assign w_match = w_match_sum;
`endif
    assign w_accept = bus.pcpi_valid & w_match;

    // ---------------- shared squarer ----------------
    logic [PROD_W-1:0]        w_sq_sig;
    logic signed [EXPX_W-1:0] w_sq_exp;
    logic                     w_sq_zero;
    logic [31:0]              w_sq_in;

    // SQ_B reuses the same squarer on rs2; every other state feeds rs1.
    assign w_sq_in = (r_state == S_SQ_B) ? r_rs2 : r_rs1;

    fp_square u_square (
        .i_exp  (w_sq_in[30:23]),
        .i_man  (w_sq_in[22:0]),
        .o_sig  (w_sq_sig),
        .o_exp  (w_sq_exp),
        .o_zero (w_sq_zero)
    );

    // ---------------- align ----------------
    // Zero squares always rank as the smaller operand; ties go to a.
    logic                     w_a_ge_b;
    logic signed [EXPX_W-1:0] w_diff;
    logic [PROD_W-1:0]        w_small_sh;

    assign w_a_ge_b = r_zero_b | (~r_zero_a & ((r_exp_a > r_exp_b) ||
                      ((r_exp_a == r_exp_b) && (r_sig_a >= r_sig_b))));
    assign w_diff   = w_a_ge_b ? (r_exp_a - r_exp_b) : (r_exp_b - r_exp_a);
    assign w_small_sh = (w_diff >= 11'sd48) ? '0 :
                        ((w_a_ge_b ? r_sig_b : r_sig_a) >> w_diff[5:0]);

    // ---------------- normalise / pack ----------------
    logic [PROD_W-1:0]        w_norm_sig;
    logic signed [EXPX_W-1:0] w_norm_exp;
    logic                     w_nan, w_inf, w_sign;
    logic [31:0]              w_result;
`ifdef PCPI_FPSQ_DIFF_EN
    logic [5:0]               w_lz;
    assign w_lz   = lzc48(r_sum[PROD_W-1:0]);
    assign w_sign = r_op_diff & r_b_bigger;
`else
    assign w_sign = 1'b0;
`endif

    always_comb begin
        w_norm_sig = r_sum[PROD_W-1:0];
        w_norm_exp = r_exp_sum;
        if (r_sum[PROD_W]) begin
            // Carry out of the add: drop the lowest bit (truncation).
            w_norm_sig = r_sum[PROD_W:1];
            w_norm_exp = r_exp_sum + 11'sd1;
        end
`ifdef PCPI_FPSQ_DIFF_EN
        else begin
            w_norm_sig = r_sum[PROD_W-1:0] << w_lz;
            w_norm_exp = r_exp_sum - $signed({5'd0, w_lz});
        end
`endif
    end

    assign w_nan = ((r_rs1[30:23] == 8'hFF) && (r_rs1[22:0] != '0)) ||
                   ((r_rs2[30:23] == 8'hFF) && (r_rs2[22:0] != '0));
    assign w_inf = (r_rs1[30:23] == 8'hFF) || (r_rs2[30:23] == 8'hFF);

    always_comb begin
        w_result = FP_ZERO;
        if (w_nan)                        w_result = FP_QNAN;
        else if (w_inf)                   w_result = FP_PINF;
        else if (r_sum == '0)             w_result = FP_ZERO;
        else if (w_norm_exp <= 11'sd0)    w_result = FP_ZERO;
        else if (w_norm_exp >= 11'sd255)  w_result = FP_PINF;
        else w_result = {w_sign, w_norm_exp[7:0], w_norm_sig[46:24]};
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: if (w_accept) begin
                r_rs1 <= bus.pcpi_rs1;
                r_rs2 <= bus.pcpi_rs2;
`ifdef PCPI_FPSQ_DIFF_EN
                r_op_diff <= w_match_diff;
`endif
            end
            S_SQ_A: begin
                r_sig_a  <= w_sq_sig;
                r_exp_a  <= w_sq_exp;
                r_zero_a <= w_sq_zero;
            end
            S_SQ_B: begin
                r_sig_b  <= w_sq_sig;
                r_exp_b  <= w_sq_exp;
                r_zero_b <= w_sq_zero;
            end
            S_ALIGN: begin
                r_sig_big   <= w_a_ge_b ? r_sig_a : r_sig_b;
                r_exp_big   <= w_a_ge_b ? r_exp_a : r_exp_b;
                r_sig_small <= w_small_sh;
                r_b_bigger  <= ~w_a_ge_b;
            end
            S_ADD: begin
                r_exp_sum <= r_exp_big;
`ifdef PCPI_FPSQ_DIFF_EN
                if (r_op_diff) r_sum <= {1'b0, r_sig_big} - {1'b0, r_sig_small};
                else           r_sum <= {1'b0, r_sig_big} + {1'b0, r_sig_small};
`else
                r_sum <= {1'b0, r_sig_big} + {1'b0, r_sig_small};
`endif
            end
            S_NORM: r_result <= w_result;
            default: ;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_SQ_A;
            S_SQ_A:  w_next_state = bus.pcpi_valid ? S_SQ_B  : S_IDLE;
            S_SQ_B:  w_next_state = bus.pcpi_valid ? S_ALIGN : S_IDLE;
            S_ALIGN: w_next_state = bus.pcpi_valid ? S_ADD   : S_IDLE;
            S_ADD:   w_next_state = bus.pcpi_valid ? S_NORM  : S_IDLE;
            S_NORM:  w_next_state = bus.pcpi_valid ? S_RESP  : S_IDLE;
            S_RESP:  w_next_state = S_COOL;
            // One dead cycle so a valid still held after ready is not re-decoded.
            S_COOL:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.pcpi_wait  = 1'b0;
        bus.pcpi_ready = 1'b0;
        bus.pcpi_wr    = 1'b0;
        bus.pcpi_rd    = '0;
        case (r_state)
            S_SQ_A, S_SQ_B, S_ALIGN, S_ADD, S_NORM: bus.pcpi_wait = 1'b1;
            S_RESP: begin
                bus.pcpi_ready = 1'b1;
                bus.pcpi_wr    = 1'b1;
                bus.pcpi_rd    = r_result;
            end
            default: ;
        endcase
    end

    logic w_unused;
    assign w_unused = ^{bus.pcpi_insn[24:15], bus.pcpi_insn[11:7],
                        r_rs1[31], r_rs2[31], w_norm_sig[47], w_norm_sig[23:0]};

endmodule

// File: tb/tb_pcpi_fp_sumsq.sv
// tb/tb_pcpi_fp_sumsq.sv - self-checking bench for pcpi_fp_sumsq
module tb_pcpi_fp_sumsq;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pcpi_fp_sumsq_if bus();

    pcpi_fp_sumsq #(.FUNCT7(7'b0000001)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int nvec = 0;
    int nerr = 0;

    localparam logic [31:0] INSN_SUM   = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    localparam logic [31:0] INSN_DIFF  = {7'b0000001, 5'd2, 5'd1, 3'b001, 5'd3, 7'b0110011};
    localparam logic [31:0] INSN_BADOP = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110111};
    localparam logic [31:0] INSN_BADF7 = {7'b0000010, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Exact a^2 + b^2 as a scaled integer, then truncated to single precision.
    function automatic logic [31:0] ref_sumsq(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, k, d, p, e;
        logic [127:0] qa, qb, s, t;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
        if (ea == 255 || eb == 255) return 32'h7F800000;
        if (ea == 0 && eb == 0) return 32'h0;
        qa = {104'd0, 1'b1, a[22:0]};
        qa = qa * qa;
        qb = {104'd0, 1'b1, b[22:0]};
        qb = qb * qb;
        if (ea == 0) begin
            s = qb; k = 2 * eb;
        end else if (eb == 0) begin
            s = qa; k = 2 * ea;
        end else if (ea >= eb) begin
            d = 2 * (ea - eb);
            if (d > 64) begin s = qa; k = 2 * ea; end
            else begin s = (qa << d) + qb; k = 2 * eb; end
        end else begin
            d = 2 * (eb - ea);
            if (d > 64) begin s = qb; k = 2 * eb; end
            else begin s = (qb << d) + qa; k = 2 * ea; end
        end
        p = 0;
        for (int i = 0; i < 128; i++) if (s[i]) p = i;
        // value = s * 2^(k-300), i.e. 1.f * 2^(p+k-300)
        e = p + k - 173;
        if (e <= 0) return 32'h0;
        if (e >= 255) return 32'h7F800000;
        t = s >> (p - 23);
        return {1'b0, 8'(e), t[22:0]};
    endfunction

    // Caller is at a negedge. hold = cycles valid stays high from the ready
    // cycle on; drop_at = cycle after which valid is dropped (0: never).
    task automatic do_op(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input int drop_at,
                         output logic [31:0] rd, output int lat, output int nready,
                         output int nwait, output int nbad);
        int post;
        post = 0;
        rd = '0; lat = -1; nready = 0; nwait = 0; nbad = 0;
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = insn;
        bus.pcpi_rs1   = a;
        bus.pcpi_rs2   = b;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.pcpi_wait) nwait++;
            if (bus.pcpi_wr !== bus.pcpi_ready) nbad++;
            if (!bus.pcpi_ready && bus.pcpi_rd !== 32'h0) nbad++;
            if (bus.pcpi_ready) begin
                nready++;
                if (lat < 0) begin lat = c; rd = bus.pcpi_rd; end
            end
            if (lat > 0) post++;
            if ((lat > 0 && post >= hold) || c == drop_at) bus.pcpi_valid = 1'b0;
        end
        bus.pcpi_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, ra, rb;
        int lat, nr, nw, nb, m, ea, eb, cnt;

        bus.pcpi_valid = 1'b0;
        bus.pcpi_insn  = '0;
        bus.pcpi_rs1   = '0;
        bus.pcpi_rs2   = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_wait",  32'(bus.pcpi_wait),  32'd0);
        chk("reset_ready", 32'(bus.pcpi_ready), 32'd0);
        chk("reset_wr",    32'(bus.pcpi_wr),    32'd0);
        chk("reset_rd",    bus.pcpi_rd,         32'd0);

        // First accept on the first edge with reset low.
        reset = 1'b0;
        do_op(INSN_SUM, 32'h42350000, 32'h40480000, 1, 0, rd, lat, nr, nw, nb);
        chk("v036_rd", rd, 32'h45009540);
        chk("v036_lat", 32'(lat), 32'd6);
        chk("v036_nready", 32'(nr), 32'd1);
        chk("v036_nwait", 32'(nw), 32'd5);
        chk("v036_wr_rd_gating", 32'(nb), 32'd0);

        do_op(INSN_SUM, 32'hC1FC0000, 32'hC0FC0000, 1, 0, rd, lat, nr, nw, nb);
        chk("v037_rd", rd, 32'h4483C880);
        do_op(INSN_SUM, 32'hC0480000, 32'h40E80000, 1, 0, rd, lat, nr, nw, nb);
        chk("v038_rd", rd, 32'h42795000);

        // Valid held through ready, cool-down and one idle cycle.
        do_op(INSN_SUM, 32'h40400000, 32'h40800000, 3, 0, rd, lat, nr, nw, nb);
        chk("hold_nready", 32'(nr), 32'd1);
        chk("hold_rd", rd, 32'h41C80000);

        // Valid dropped while in ADD.
        do_op(INSN_SUM, 32'h40400000, 32'h40800000, 1, 4, rd, lat, nr, nw, nb);
        chk("abort_nready", 32'(nr), 32'd0);
        chk("abort_nwait", 32'(nw), 32'd4);

        do_op(INSN_SUM, 32'h7FC00000, 32'h3F800000, 1, 0, rd, lat, nr, nw, nb);
        chk("nan_rd", rd, 32'h7FC00000);
        do_op(INSN_SUM, 32'h7F800000, 32'h7FC00001, 1, 0, rd, lat, nr, nw, nb);
        chk("inf_nan_rd", rd, 32'h7FC00000);
        do_op(INSN_SUM, 32'hFF800000, 32'h3F800000, 1, 0, rd, lat, nr, nw, nb);
        chk("inf_rd", rd, 32'h7F800000);
        do_op(INSN_SUM, 32'h7F000000, 32'h00000000, 1, 0, rd, lat, nr, nw, nb);
        chk("ovf_rd", rd, 32'h7F800000);
        do_op(INSN_SUM, 32'h00000001, 32'h00000000, 1, 0, rd, lat, nr, nw, nb);
        chk("denorm_rd", rd, 32'h00000000);
        do_op(INSN_SUM, 32'h1F000000, 32'h00000000, 1, 0, rd, lat, nr, nw, nb);
        chk("unf_rd", rd, 32'h00000000);

        do_op(INSN_BADOP, 32'h3F800000, 32'h3F800000, 1, 0, rd, lat, nr, nw, nb);
        chk("badop_nwait", 32'(nw), 32'd0);
        chk("badop_nready", 32'(nr), 32'd0);
        do_op(INSN_BADF7, 32'h3F800000, 32'h3F800000, 1, 0, rd, lat, nr, nw, nb);
        chk("badf7_nwait", 32'(nw), 32'd0);

`ifdef PCPI_FPSQ_DIFF_EN
        do_op(INSN_DIFF, 32'h40400000, 32'h40A00000, 1, 0, rd, lat, nr, nw, nb);
        chk("diff_rd", rd, 32'hC1800000);
        chk("diff_lat", 32'(lat), 32'd6);
        do_op(INSN_DIFF, 32'h40400000, 32'hC0400000, 1, 0, rd, lat, nr, nw, nb);
        chk("diff_zero_rd", rd, 32'h00000000);
`else
        do_op(INSN_DIFF, 32'h40400000, 32'h40A00000, 1, 0, rd, lat, nr, nw, nb);
        chk("diff_off_nwait", 32'(nw), 32'd0);
        chk("diff_off_nready", 32'(nr), 32'd0);
`endif

        // Reset while in ALIGN.
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = INSN_SUM;
        bus.pcpi_rs1   = 32'h40400000;
        bus.pcpi_rs2   = 32'h40800000;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bus.pcpi_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_wait",  32'(bus.pcpi_wait),  32'd0);
        chk("rst_mid_ready", 32'(bus.pcpi_ready), 32'd0);
        chk("rst_mid_wr",    32'(bus.pcpi_wr),    32'd0);
        chk("rst_mid_rd",    bus.pcpi_rd,         32'd0);
        reset = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.pcpi_ready || bus.pcpi_wait) cnt++;
        end
        chk("rst_mid_no_resp", 32'(cnt), 32'd0);

        for (int i = 0; i < 48; i++) begin
            m = int'($urandom_range(0, 3));
            if (m < 2) begin
                ea = int'($urandom_range(107, 147));
                eb = int'($urandom_range(107, 147));
            end else if (m == 2) begin
                ea = int'($urandom_range(0, 255));
                eb = int'($urandom_range(0, 255));
            end else begin
                ea = int'($urandom_range(1, 254));
                eb = ea + int'($urandom_range(0, 60)) - 30;
                if (eb < 1) eb = 1;
                if (eb > 254) eb = 254;
            end
            ra = {1'($urandom), 8'(ea), 23'($urandom)};
            rb = {1'($urandom), 8'(eb), 23'($urandom)};
            do_op(INSN_SUM, ra, rb, 1, 0, rd, lat, nr, nw, nb);
            chk($sformatf("rand%0d_rd a=%h b=%h", i, ra, rb), rd, ref_sumsq(ra, rb));
            chk($sformatf("rand%0d_lat", i), 32'(lat), 32'd6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pcpi_fp_sumsq.md
PCPI_FP_SUMSQ -- requirements
Module: pcpi_fp_sumsq

Interface
REQ-001 Parameter FUNCT7, default 7'b0000001: funct7 value this unit decodes.
REQ-002 clk  input  1  sole clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous reset, active-high.
REQ-004 pcpi_valid  input  1  the core presents an instruction; held high until pcpi_ready.
REQ-005 pcpi_insn  input  32  instruction word under decode.
REQ-006 pcpi_rs1  input  32  operand a, IEEE-754 single.
REQ-007 pcpi_rs2  input  32  operand b, IEEE-754 single.
REQ-008 pcpi_wr  output  1  result is written to rd; high only with pcpi_ready.
REQ-009 pcpi_rd  output  32  result, IEEE-754 single; valid only while pcpi_ready=1.
REQ-010 pcpi_wait  output  1  instruction claimed, result pending.
REQ-011 pcpi_ready  output  1  one-cycle completion pulse.

Function
REQ-012 Match: pcpi_insn[6:0]=7'b0110011, [31:25]=FUNCT7, [14:12]=3'b000 selects SUMSQ (rd = a*a + b*b).
REQ-013 FSM states: IDLE, SQ_A, SQ_B, ALIGN, ADD, NORM, RESP, COOL.
REQ-014 IDLE->SQ_A when pcpi_valid & match; rs1/rs2/op latched on that edge.
REQ-015 Fixed progression SQ_A->SQ_B->ALIGN->ADD->NORM->RESP->COOL->IDLE, one cycle each.
REQ-016 pcpi_wait=1 in every state from SQ_A through NORM; 0 in IDLE, RESP and COOL.
REQ-017 In RESP, pcpi_ready=1 and pcpi_wr=1 for exactly one cycle, 6 cycles after the accept edge; pcpi_rd is 0 in all other states.
REQ-018 COOL blocks re-accept for one cycle, so a still-high pcpi_valid after ready is never decoded twice.
REQ-019 Non-matching instruction: no output changes; the unit stays in IDLE.
REQ-020 pcpi_valid dropping in SQ_A..NORM: abort to IDLE next cycle; no ready, no wr.
REQ-021 Squaring: the 24-bit significand (hidden 1) is squared to 48 bits; exponent is 2e-127, with +1 when product bit 47 is set.
REQ-022 Sign of each square is 0, so SUMSQ adds two non-negative values without cancellation.
REQ-023 ALIGN shifts the smaller operand right by the exponent difference; a difference of 48 or more zeroes it.
REQ-024 Rounding is truncation (round toward zero) in every step.
REQ-025 Denormal input is flushed to zero; result exponent <= 0 gives 0x00000000.
REQ-026 Result exponent >= 255 gives 0x7F800000.
REQ-027 Any NaN input gives 0x7FC00000; otherwise any Inf input gives 0x7F800000.

Reset
REQ-028 reset=1 at any clock edge forces state IDLE and pcpi_wr=pcpi_rd=pcpi_wait=pcpi_ready=0.
REQ-029 Reset mid-operation discards the operation; no ready is ever issued for it.
REQ-030 First accept is possible on the first edge with reset=0.

Configuration
REQ-031 Macro PCPI_FPSQ_DIFF_EN defined: funct3=3'b001 also matches and gives DIFFSQ (rd = a*a - b*b), with the same latency.
REQ-032 DIFFSQ sign comes from the larger magnitude; the NORM leading-zero shift covers up to 48 bits; an exact-zero result is +0.
REQ-033 Macro undefined: funct3=3'b001 does not match and the subtract datapath is absent.

Structure
REQ-034 Shared package pcpi_fpsq_pkg: state enum; field widths (EXP_W=8, MAN_W=23); constants FP_QNAN, FP_PINF, FP_ZERO; OPCODE_OP.
REQ-035 Sub-module fp_square (combinational 24x24 significand squarer with exponent), instantiated once and time-shared by SQ_A and SQ_B.

Verification
REQ-036 rs1=0x42350000, rs2=0x40480000, SUMSQ -> pcpi_rd=0x45009540, ready 6 cycles after accept.
REQ-037 rs1=0xC1FC0000, rs2=0xC0FC0000 -> 0x4483C880.
REQ-038 rs1=0xC0480000, rs2=0x40E80000 -> 0x42795000.
REQ-039 pcpi_valid held high 3 cycles past ready -> exactly one ready pulse; valid dropped in ADD -> no ready.
REQ-040 Special and boundary inputs: rs1=0x7FC00000 -> 0x7FC00000; rs1=0x7F000000 -> 0x7F800000; rs1=0x00000001, rs2=0 -> 0x00000000; reset in ALIGN -> all outputs 0, IDLE.
REQ-041 With PCPI_FPSQ_DIFF_EN, funct3=001, rs1=0x40400000 (3.0), rs2=0x40A00000 (5.0) -> 0xC1800000 (-16.0); without the macro -> no pcpi_wait.
